// File: rtl/fft_output_reader_pkg.sv
// Shared constants, beat record and index helpers for the FFT unload path.
// Bank layout: a DIF result at bit-reversed position idx lives in bank ^idx at address idx>>1.
package fft_pkg;

    localparam int LOGN = 6;
    localparam int N    = 1 << LOGN;
    localparam int DW   = 16;
    localparam int AW   = LOGN - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [LOGN-1:0] index;
        logic            last;
    } beat_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = idx[LOGN-1-i];
        end
        return r;
    endfunction

    function automatic logic bank_of(input logic [LOGN-1:0] idx);
        return ^idx;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [LOGN-1:0] idx);
        return idx[LOGN-1:1];
    endfunction

endpackage

// File: rtl/fft_output_reader_if.sv
// SRAM read ports, control and output stream of the FFT unload block.
// master = the reader, slave = the SRAM/controller/consumer environment.
interface fft_output_reader_if;
    import fft_pkg::*;

    logic                start;
    logic [2*DW-1:0]     rdata_b0;
    logic [2*DW-1:0]     rdata_b1;
    logic                re_b0;
    logic                re_b1;
    logic [AW-1:0]       raddr_b0;
    logic [AW-1:0]       raddr_b1;
    logic                out_valid;
    logic                out_ready;
    logic [2*DW-1:0]     out_data;
    logic [LOGN-1:0]     out_index;
    logic                out_last;
    logic                busy;
    logic                done;

    modport master (
        input  start, rdata_b0, rdata_b1, out_ready,
        output re_b0, re_b1, raddr_b0, raddr_b1,
               out_valid, out_data, out_index, out_last, busy, done
    );

    modport slave (
        output start, rdata_b0, rdata_b1, out_ready,
        input  re_b0, re_b1, raddr_b0, raddr_b1,
               out_valid, out_data, out_index, out_last, busy, done
    );

endinterface

// File: rtl/fft_output_reader_out_buf.sv
// Two-entry beat FIFO; a push is visible at the head the cycle after it is written.
// Head entry is held unchanged while out_valid & ~pop; caller never pushes into a full buffer.
module fft_out_buf
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output logic       out_valid,
    output beat_t      out_beat,
    output logic [1:0] occ
);

    beat_t      mem_q [2];
    beat_t      mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_beat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_beat  = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fft_output_reader.sv
// Unloads 64 DIF results from two parity-interleaved banks in natural order; first beat 3 cycles after start.
// Reads are throttled so buffered + in-flight beats never exceed 2; 1 beat/cycle with out_ready held high.
module fft_output_reader
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fft_output_reader_if.master bus
);

    state_t          state_q, state_d;
    logic [LOGN-1:0] m_q, m_d;
    logic            inflight_q, inflight_d;
    logic            bank_q, bank_d;
    logic [LOGN-1:0] ret_m_q, ret_m_d;
    logic            done_q, done_d;

    logic            issue;
    logic            pop;
    logic            buf_valid;
    logic [1:0]      occ;
    beat_t           push_beat;
    beat_t           head_beat;
    logic [LOGN-1:0] idx;
    logic            cur_bank;

    assign idx      = bitrev(m_q);
    assign cur_bank = bank_of(idx);
    assign pop      = buf_valid & bus.out_ready;

    // A pop frees a slot this cycle, so issuing alongside it keeps the stream gapless.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    m_d     = '0;
                end
            end
            RUN: begin
                issue = ((occ + {1'b0, inflight_q}) < 2'd2) | pop;
                if (issue) begin
                    m_d = m_q + LOGN'(1);
                    if (m_q == LOGN'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_beat.last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        bank_d     = issue ? cur_bank : bank_q;
        ret_m_d    = issue ? m_q : ret_m_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            inflight_q <= 1'b0;
            bank_q     <= 1'b0;
            ret_m_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            inflight_q <= inflight_d;
            bank_q     <= bank_d;
            ret_m_q    <= ret_m_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        push_beat.data  = bank_q ? bus.rdata_b1 : bus.rdata_b0;
        push_beat.index = ret_m_q;
        push_beat.last  = (ret_m_q == LOGN'(N - 1));
    end

    fft_out_buf u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_beat (push_beat),
        .pop       (pop),
        .out_valid (buf_valid),
        .out_beat  (head_beat),
        .occ       (occ)
    );

    // Address follows m_q, which only moves on an issue, so it is stable between reads.
    assign bus.re_b0     = issue & ~cur_bank;
    assign bus.re_b1     = issue & cur_bank;
    assign bus.raddr_b0  = addr_of(idx);
    assign bus.raddr_b1  = addr_of(idx);
    assign bus.out_valid = buf_valid;
    assign bus.out_data  = head_beat.data;
    assign bus.out_index = head_beat.index;
    assign bus.out_last  = head_beat.last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_fft_output_reader.sv
// Directed bench for fft_output_reader with an SRAM bank model and an expected-beat queue.
module tb_fft_output_reader;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_output_reader_if bus ();

    fft_output_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] bank0 [32];
    logic [31:0] bank1 [32];

    always @(posedge clk) begin
        if (bus.re_b0) bus.rdata_b0 <= bank0[bus.raddr_b0];
        if (bus.re_b1) bus.rdata_b1 <= bank1[bus.raddr_b1];
    end

    typedef struct {
        logic [31:0] data;
        logic [5:0]  index;
        logic        last;
    } exp_t;

    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          issued = 0;
    int          popped = 0;
    int          done_cnt = 0;
    int          cyc_n = 0;
    int          first_pop_cyc = 0;
    int          last_pop_cyc = 0;
    logic        exp_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] h_data;
    logic [5:0]  h_idx;
    logic        h_last;

    function automatic logic [5:0] rev6(input logic [5:0] v);
        logic [5:0] r;
        r = {<<{v}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic monitor();
        logic [5:0] m_l;
        logic [5:0] idx_l;
        logic       b_l;
        exp_t       e;
        cyc_n++;
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        chk("done_timing", bus.done, exp_done);
        if (bus.done) done_cnt++;
        if (bus.re_b0 || bus.re_b1) begin
            m_l   = 6'(issued);
            idx_l = rev6(m_l);
            b_l   = ($countones(idx_l) % 2) == 1;
            chk("re_bank", {bus.re_b1, bus.re_b0}, b_l ? 2'b10 : 2'b01);
            chk("raddr_b0", bus.raddr_b0, idx_l / 2);
            chk("raddr_b1", bus.raddr_b1, idx_l / 2);
            issued++;
        end
        if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out_data, h_data);
            chk("hold_index", bus.out_index, h_idx);
            chk("hold_last", bus.out_last, h_last);
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("beat_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_index", bus.out_index, e.index);
                chk("out_last", bus.out_last, e.last);
            end
            popped++;
            if (popped == 1) first_pop_cyc = cyc_n;
            last_pop_cyc = cyc_n;
        end
        chk("outstanding_le_2", (issued - popped) <= 2, 1'b1);
        prev_stall = bus.out_valid & ~bus.out_ready;
        h_data     = bus.out_data;
        h_idx      = bus.out_index;
        h_last     = bus.out_last;
        exp_done   = bus.out_valid & bus.out_ready & bus.out_last;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        exp_t e;
        for (int m = 0; m < 64; m++) begin
            e.data  = 32'(rev6(6'(m)));
            e.index = 6'(m);
            e.last  = (m == 63);
            sb.push_back(e);
        end
        issued    = 0;
        popped    = 0;
        done_cnt  = 0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        for (int i = 0; i < maxc && done_cnt == 0; i++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
        end
        bus.out_ready = 1'b1;
        chk("done_seen", done_cnt > 0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            if (($countones(i[5:0]) % 2) == 1) bank1[i / 2] = 32'(i);
            else                               bank0[i / 2] = 32'(i);
        end
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_re", {bus.re_b1, bus.re_b0}, 2'b00);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_index", bus.out_index, 6'd0);
        chk("rst_out_last", bus.out_last, 1'b0);
        rst = 1'b0;
        cyc();

        // Full throughput, latency and address map.
        bus.out_ready = 1'b1;
        start_run();
        chk("t1_re_b0_m0", bus.re_b0, 1'b1);
        chk("t1_raddr_m0", bus.raddr_b0, 5'd0);
        chk("t1_valid", bus.out_valid, 1'b0);
        chk("t1_busy", bus.busy, 1'b1);
        cyc();
        chk("t2_re_b1_m1", bus.re_b1, 1'b1);
        chk("t2_raddr_m1", bus.raddr_b1, 5'd16);
        chk("t2_valid", bus.out_valid, 1'b0);
        cyc();
        chk("t3_valid", bus.out_valid, 1'b1);
        chk("t3_index", bus.out_index, 6'd0);
        cyc();
        chk("t4_re_b0_m3", bus.re_b0, 1'b1);
        chk("t4_raddr_m3", bus.raddr_b0, 5'd24);
        wait_done(200, 1'b0);
        chk("t1_consecutive", last_pop_cyc - first_pop_cyc, 63);
        chk("t1_beats", popped, 64);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_busy_after", bus.busy, 1'b0);
        chk("t1_done_pulse", bus.done, 1'b0);

        // Random backpressure.
        start_run();
        wait_done(2000, 1'b1);
        chk("t2_beats", popped, 64);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_done_cnt", done_cnt, 1);

        // Restart attempt mid-stream is ignored.
        bus.out_ready = 1'b1;
        start_run();
        for (int i = 0; i < 200 && popped < 20; i++) cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_done(200, 1'b0);
        repeat (5) cyc();
        chk("t3_beats", popped, 64);
        chk("t3_done_once", done_cnt, 1);
        chk("t3_idle", bus.busy, 1'b0);

        // Reset mid-stream flushes everything.
        start_run();
        for (int i = 0; i < 200 && popped < 30; i++) cyc();
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        chk("t4_valid", bus.out_valid, 1'b0);
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_done", bus.done, 1'b0);
        chk("t4_re", {bus.re_b1, bus.re_b0}, 2'b00);
        sb.delete();
        repeat (4) cyc();
        chk("t4_no_done", done_cnt, 0);
        bus.out_ready = 1'b1;
        start_run();
        wait_done(200, 1'b0);
        chk("t4b_beats", popped, 64);
        chk("t4b_sb_empty", sb.size(), 0);

        // Consumer stalled right after start.
        bus.out_ready = 1'b0;
        start_run();
        repeat (10) cyc();
        chk("t5_issued", issued, 2);
        chk("t5_re_idle", {bus.re_b1, bus.re_b0}, 2'b00);
        chk("t5_valid", bus.out_valid, 1'b1);
        chk("t5_index", bus.out_index, 6'd0);
        chk("t5_data", bus.out_data, 32'd0);
        wait_done(200, 1'b0);
        chk("t5_beats", popped, 64);
        chk("t5_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_output_reader.md
Name: fft_output_reader

Overview:
- Unload side of the in-place radix-2 DIF FFT with dual-bank (b0/b1) single-write/single-read SRAM storage.
- Starts on the FFT controller's output_start pulse. Reads the 64 results out of the two banks and undoes both the parity bank interleave and the DIF bit-reversed ordering.
- Streams results in natural frequency order over a valid/ready interface.
- Sits between the SRAM banks' read ports and the downstream consumer.

Parameters:
- DW, 16, width of each real/imag component; a bank word is 2*DW bits (real in upper half).
- LOGN, 6, log2 of FFT size N (N = 64).
- AW, LOGN-1, bank address width (5).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse from FFT controller (output_start); begin unload
- rdata_b0  in  2*DW  bank0 read data, valid 1 cycle after re_b0
- rdata_b1  in  2*DW  bank1 read data, valid 1 cycle after re_b1
- re_b0  out  1  bank0 read enable
- re_b1  out  1  bank1 read enable
- raddr_b0  out  AW  bank0 read address
- raddr_b1  out  AW  bank1 read address
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- out_data  out  2*DW  X[m]
- out_index  out  LOGN  m, natural-order bin index
- out_last  out  1  high with beat m = N-1
- busy  out  1  high from the cycle after start until the last beat is accepted
- done  out  1  one-cycle pulse the cycle after the last beat is accepted

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; buffer empty.
- Address map, per natural index m:
  - idx = bitrev_LOGN(m)
  - bank = XOR-reduce(idx)
  - addr = idx >> 1
  - Bank 0 when parity is even, bank 1 when odd.
- Read issue: re_b0 = issue & ~bank, re_b1 = issue & bank. raddr_b0 and raddr_b1 are both driven with addr. Addresses are don't-care when not issuing but must be stable (hold last).
- Read return path:
  - bank and m are registered alongside the issue (1-cycle SRAM latency).
  - The returned word is muxed from rdata_b0/rdata_b1 by the registered bank.
  - It is pushed into the 2-entry output buffer with its index and last flag.
- Flow control:
  - issue = RUN & (occ + inflight < 2 | pop), where pop = out_valid & out_ready and inflight is a 0/1 flag.
  - The buffer never overflows.
  - Full throughput (1 beat/cycle) when out_ready is held high.
- FSM:
  - IDLE: on start, go to RUN and clear the issue counter m.
  - RUN: increment m on each issue. After issuing m = N-1, go to DRAIN.
  - DRAIN: no issues. When the out_last beat is popped, pulse done and go to IDLE.
- Latency: start sampled at edge T; first read issued in cycle T+1; first out_valid in cycle T+3.
- Output holds: out_data, out_index and out_last stay stable while out_valid & ~out_ready.
- start while busy: ignored, no restart.
- start in the same cycle as the done pulse: accepted, goes to RUN.
- Reset mid-operation: immediate return to IDLE; buffer flushed; out_valid and re_* low the next cycle; no done pulse.
- m wraps only through IDLE. The issue counter is LOGN+1 bits or flag-terminated, so there is no aliasing at 63→0.

Decomposition:
- Package fft_pkg holds:
  - constants N, LOGN, DW
  - function bitrev(idx)
  - function bank_of(idx), the parity XOR-reduce
  - FSM state encoding IDLE/RUN/DRAIN
- Sub-module fft_out_buf: 2-entry FIFO carrying {data, index, last}, with push/pop, occ and out_valid. The top holds the FSM, address generation and read-return mux.

Test Plan:
- Preload model banks so that each word = its idx (bank parity(idx), addr idx>>1). With out_ready=1 and a start pulse → 64 beats in consecutive cycles; first beat at start+3; out_data sequence 0,32,16,48,8,…,63 equals bitrev(m); out_last only on m=63; done pulse 1 cycle after the last beat.
- Address check → m=1 gives re_b1, raddr_b1=16; m=3 gives re_b0, raddr_b0=24; m=0 gives re_b0, raddr 0.
- Random out_ready (50%) → same 64 values in order, no drops or duplicates, outputs stable during stalls, at most 2 reads outstanding beyond the buffer.
- Second start pulse at beat 20 → ignored, stream continues to m=63, exactly one done.
- rst asserted at beat 30 → next cycle out_valid=0, busy=0, no done. A fresh start then yields a full, correct 64-beat stream.
- out_ready=0 for 10 cycles right after start → reads stop after the buffer fills (2 entries); first beat m=0 is held stable until accepted.
